// File: rtl/var_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : var_delay_line
//  Purpose  : Run-time programmable delay line (1..MAX_DEPTH en-cycles) with
//             valid tagging, stall support and a settle sequence after every
//             delay change so stale words are never flagged valid.
//  Options  : VAR_DELAY_LINE_BYPASS_EN - delay_cfg=0 selects a zero-latency
//             combinational bypass instead of clamping to 1.
//  Revision : 1.0 - initial release
// ============================================================================
module var_delay_line #(
   parameter int WIDTH       = 32,
   parameter int MAX_DEPTH   = 8,
   parameter int DW          = 8,
   parameter int RESET_DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic [DW-1:0]    delay_cfg,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             busy,
   output logic [DW-1:0]    cur_delay
);

   localparam logic [DW-1:0] MAX_DELAY = DW'(MAX_DEPTH);
   localparam logic [DW-1:0] RST_DELAY = DW'(RESET_DELAY);
`ifdef VAR_DELAY_LINE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_SETTLE = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        cur_delay_q, cur_delay_d;
   logic [DW-1:0]        settle_cnt_q, settle_cnt_d;
   logic [DW-1:0]        cfg_clamped;
   logic                 zero_sel;
   logic [MAX_DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]     data_q [MAX_DEPTH];
   logic [WIDTH-1:0]     data_d [MAX_DEPTH];
   logic [WIDTH-1:0]     tap_data;
   logic                 tap_valid;

   // Clamp the requested delay into the legal range (0 kept only for bypass).
   always_comb begin
      cfg_clamped = delay_cfg;
      if (delay_cfg > MAX_DELAY) begin
         cfg_clamped = MAX_DELAY;
      end
`ifndef VAR_DELAY_LINE_BYPASS_EN
      else if (delay_cfg == '0) begin
         cfg_clamped = DW'(1);
      end
`endif
      zero_sel = BYPASS && (cfg_clamped == '0);
   end

   // Shift the {valid, data} stages on every enabled cycle, hold otherwise.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (en) begin
         valid_d   = {valid_q[MAX_DEPTH-2:0], in_valid};
         data_d[0] = data_in;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            data_d[i] = data_q[i-1];
         end
      end
   end

   // Next-state logic: a load restarts the settle count (last load wins);
   // otherwise SETTLE counts down enabled cycles until the line has refilled.
   always_comb begin
      state_d      = state_q;
      cur_delay_d  = cur_delay_q;
      settle_cnt_d = settle_cnt_q;
      if (load && ((state_q == ST_SETTLE) || (cfg_clamped != cur_delay_q))) begin
         cur_delay_d = cfg_clamped;
         if (zero_sel) begin
            // Bypass taps data_in directly, so there is nothing to flush.
            state_d      = ST_RUN;
            settle_cnt_d = '0;
         end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = cfg_clamped;
         end
      end else if ((state_q == ST_SETTLE) && en) begin
         settle_cnt_d = settle_cnt_q - DW'(1);
         if (settle_cnt_q == DW'(1)) begin
            state_d = ST_RUN;
         end
      end
   end

   // State, delay and storage registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         cur_delay_q  <= RST_DELAY;
         settle_cnt_q <= '0;
         valid_q      <= '0;
         for (int i = 0; i < MAX_DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cur_delay_q  <= cur_delay_d;
         settle_cnt_q <= settle_cnt_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
      end
   end

   // Select stage (cur_delay-1) and qualify it; out_valid is masked while busy.
   always_comb begin
      tap_data  = '0;
      tap_valid = 1'b0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (cur_delay_q == DW'(i + 1)) begin
            tap_data  = data_q[i];
            tap_valid = valid_q[i];
         end
      end
      busy      = (state_q == ST_SETTLE);
      cur_delay = cur_delay_q;
      data_out  = tap_data;
      out_valid = tap_valid & ~busy;
`ifdef VAR_DELAY_LINE_BYPASS_EN
      if (cur_delay_q == '0) begin
         data_out  = data_in;
         out_valid = in_valid;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_var_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_var_delay_line
//  Purpose  : Directed self-checking bench for var_delay_line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_var_delay_line;

   localparam int WIDTH       = 32;
   localparam int MAX_DEPTH   = 8;
   localparam int DW          = 8;
   localparam int RESET_DELAY = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic             in_valid;
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic [DW-1:0]    delay_cfg;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             busy;
   logic [DW-1:0]    cur_delay;

   int n_checks = 0;
   int n_errors = 0;

   var_delay_line #(
      .WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DW(DW), .RESET_DELAY(RESET_DELAY)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .data_in(data_in),
      .load(load), .delay_cfg(delay_cfg), .data_out(data_out),
      .out_valid(out_valid), .busy(busy), .cur_delay(cur_delay)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run with en=1 until busy drops, bounded; returns cycles spent busy.
   task automatic drain(output int n, output int saw_valid);
      n = 0;
      saw_valid = 0;
      while (busy && n < 20) begin
         if (out_valid) saw_valid = 1;
         tick();
         n++;
      end
   endtask

   // Issue a one-cycle load strobe with en=1.
   task automatic do_load(input logic [DW-1:0] cfg);
      load = 1'b1; delay_cfg = cfg;
      tick();
      load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, sv, j;
      logic exp_v;
      reset = 1'b0; en = 1'b0; in_valid = 1'b0; data_in = '0;
      load = 1'b0; delay_cfg = '0;
      repeat (2) tick();
      check("rst_cur_delay", 32'(cur_delay), RESET_DELAY);
      check("rst_busy",      32'(busy),      0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_data_out",  data_out,       0);
      reset = 1'b1;
      tick();

      // Delay 1: word visible right after the edge that accepts it.
      en = 1'b1; in_valid = 1'b1; data_in = 32'hA5A5_0001;
      check("d1_pre_valid", 32'(out_valid), 0);
      tick();
      check("d1_valid", 32'(out_valid), 1);
      check("d1_data",  data_out, 32'hA5A5_0001);
      in_valid = 1'b0; data_in = '0;
      tick();
      check("d1_after_valid", 32'(out_valid), 0);

      // Delay 5: busy for exactly 5 en-cycles, then 3-word stream.
      do_load(8'd5);
      check("d5_cur_delay", 32'(cur_delay), 5);
      check("d5_busy_start", 32'(busy), 1);
      drain(n, sv);
      check("d5_busy_cycles", n, 5);
      check("d5_valid_while_busy", sv, 0);
      for (int t = 0; t < 8; t++) begin
         in_valid = (t < 3);
         data_in  = 32'h10 + 32'(t);
         tick();
         exp_v = (t >= 4 && t <= 6);
         check("d5_stream_valid", 32'(out_valid), 32'(exp_v));
         if (exp_v) check("d5_stream_data", data_out, 32'h10 + 32'(t - 4));
      end
      in_valid = 1'b0;

      // Delay 4 with en toggling: stalls do not count toward latency.
      do_load(8'd4);
      drain(n, sv);
      check("d4_busy_cycles", n, 4);
      j = 0;
      for (int t = 0; t < 24; t++) begin
         en       = (t % 2 == 0);
         in_valid = en && (j < 8);
         data_in  = 32'h20 + 32'(j);
         tick();
         if (en) j++;
         exp_v = (j >= 4 && j <= 11);
         check("d4_stall_valid", 32'(out_valid), 32'(exp_v));
         if (exp_v) check("d4_stall_data", data_out, 32'h20 + 32'(j - 4));
      end
      en = 1'b1; in_valid = 1'b0;

      // Clamping at both ends, and a reload of the same value.
      do_load(8'd0);
`ifdef VAR_DELAY_LINE_BYPASS_EN
      check("clamp_zero", 32'(cur_delay), 0);
      check("bypass_busy", 32'(busy), 0);
      in_valid = 1'b1; data_in = 32'hBEEF_0000;
      #1;
      check("bypass_data", data_out, 32'hBEEF_0000);
      check("bypass_valid", 32'(out_valid), 1);
      in_valid = 1'b0;
`else
      check("clamp_zero", 32'(cur_delay), 1);
`endif
      drain(n, sv);
      do_load(8'd200);
      check("clamp_high", 32'(cur_delay), MAX_DEPTH);
      drain(n, sv);
      check("clamp_high_busy_cycles", n, MAX_DEPTH);
      do_load(8'd8);
      check("same_load_busy", 32'(busy), 0);
      check("same_load_cur", 32'(cur_delay), 8);

      // Load 6, then load 2 two cycles later: last load wins.
      in_valid = 1'b1; data_in = 32'h40;
      do_load(8'd6);
      check("l6_busy", 32'(busy), 1);
      check("l6_out_valid", 32'(out_valid), 0);
      data_in = 32'h41;
      tick();
      check("l6_out_valid2", 32'(out_valid), 0);
      data_in = 32'h42;
      do_load(8'd2);
      check("l2_cur_delay", 32'(cur_delay), 2);
      check("l2_busy0", 32'(busy), 1);
      check("l2_out_valid0", 32'(out_valid), 0);
      data_in = 32'h43;
      tick();
      check("l2_busy1", 32'(busy), 1);
      check("l2_out_valid1", 32'(out_valid), 0);
      data_in = 32'h44;
      tick();
      check("l2_busy_clear", 32'(busy), 0);
      check("l2_valid_after", 32'(out_valid), 1);
      check("l2_data_after", data_out, 32'h43);
      in_valid = 1'b0;

      // Asynchronous reset in the middle of SETTLE.
      do_load(8'd7);
      tick();
      check("r7_busy", 32'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_busy", 32'(busy), 0);
      check("async_out_valid", 32'(out_valid), 0);
      check("async_cur_delay", 32'(cur_delay), RESET_DELAY);
      check("async_data_out", data_out, 0);
      reset = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/var_delay_line.md
Name: var_delay_line

Overview:
- Run-time programmable delay line for protocol datapaths, e.g. aligning checksum/length fields against the payload stream in UDP/TCP header builders.
- Holds up to MAX_DEPTH WIDTH-bit words, each with a valid bit.
- Delay is selectable 1..MAX_DEPTH.
- Supports stall (en), valid tagging and a controlled reconfiguration sequence so that stale data is never presented as valid after a delay change.

Parameters:
- WIDTH, 32: data word width in bits.
- MAX_DEPTH, 8: number of storage stages; maximum delay. Must be >= 2.
- DW, 8: width of delay_cfg and cur_delay. Must satisfy 2^DW > MAX_DEPTH.
- RESET_DELAY, 1: active delay after reset, 1..MAX_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  one clock; reset is asynchronous and active-low.
- en  input  1  advance enable; when 0 the line holds all state.
- in_valid  input  1  qualifier for data_in.
- data_in  input  WIDTH  input word.
- load  input  1  one-cycle strobe: adopt delay_cfg as the new delay.
- delay_cfg  input  DW  requested delay, in en-cycles.
- data_out  output  WIDTH  tap of stage (cur_delay-1), combinational from registers.
- out_valid  output  1  data_out valid; forced 0 while busy.
- busy  output  1  reconfiguration in progress.
- cur_delay  output  DW  currently active delay, registered.

Behaviour:
- Storage
  - stage[0..MAX_DEPTH-1], each holding {valid, data}.
  - On a clk edge with en=1: stage[0] <= {in_valid, data_in}; stage[i] <= stage[i-1].
  - With en=0 nothing shifts. The settle counter also holds.
- Latency
  - A word accepted with in_valid=1 on en-cycle N appears on data_out, with out_valid=1, after exactly cur_delay en-cycles.
  - Stalled cycles do not count.
- Reset (asynchronous, reset=0)
  - All stage valid bits 0 and all data 0.
  - cur_delay = RESET_DELAY, busy = 0, out_valid = 0, data_out = 0, state = RUN.
- Delay clamping, applied at load
  - 0 becomes 1.
  - Values above MAX_DEPTH become MAX_DEPTH.
- State machine: RUN, SETTLE.
  - RUN, load=1 with clamped value == cur_delay: no effect; stay in RUN.
  - RUN, load=1 with a different value: cur_delay <= new value; settle_cnt <= new value; go to SETTLE; busy=1 from the next cycle.
  - SETTLE: each en-cycle decrements settle_cnt. When it reaches 0, return to RUN and busy=0.
  - SETTLE, load=1: restart with the newest value, regardless of its value. Last load wins.
- Output qualification
  - out_valid = stage[cur_delay-1].valid AND NOT busy.
  - data_out is driven in every state; ignore it when out_valid=0.
- Simultaneous events
  - load and en in the same cycle: the shift happens, cur_delay updates at the same edge, and the settle count begins on the following en-cycle.
  - Input accepted during SETTLE is kept and emerges once RUN resumes.
- Reset mid-SETTLE: immediately returns to RUN with RESET_DELAY and an empty line.
- No backpressure output: the line never refuses data. The consumer must honour out_valid.

Optional Feature:
- Macro: VAR_DELAY_LINE_BYPASS_EN.
- Defined:
  - delay_cfg=0 is legal and selects zero-latency bypass.
  - data_out = data_in and out_valid = in_valid, combinationally.
  - cur_delay reads 0 and busy is not asserted for a change to 0.
  - Stages keep shifting with en, so a later change to a non-zero delay still performs SETTLE.
- Not defined:
  - 0 clamps to 1 as described above.
  - No combinational path exists from data_in to data_out.

Test Plan:
- Reset release, then RESET_DELAY=1, en=1, in_valid=1, data_in=0xA5A5_0001 -> data_out=0xA5A5_0001 with out_valid=1 exactly 1 cycle later; out_valid=0 before that.
- load with delay_cfg=5, then wait for busy=0; stream 0x10,0x11,0x12 -> each appears 5 en-cycles after entry, in order; busy is high for exactly 5 en-cycles after load.
- Delay 4, stream 0x20..0x27 with en toggling 1,0,1,0 -> outputs unchanged in order; each word out after 4 en=1 cycles; no duplicates or drops.
- delay_cfg=0 and then 200 with MAX_DEPTH=8 -> cur_delay reads 1, then 8. With VAR_DELAY_LINE_BYPASS_EN, 0 -> cur_delay=0 and data_out equals data_in in the same cycle.
- load 6, then load 2 two cycles later during SETTLE -> cur_delay=2; busy clears 2 en-cycles after the second load; out_valid stays 0 throughout.
- Assert reset for 1 ns mid-SETTLE (delay 7) -> busy=0, out_valid=0 and cur_delay=RESET_DELAY immediately, without waiting for a clk edge.
